// File: rtl/midi_msg_parser_pkg.sv
// Shared MIDI types: event encoding, status-byte constants and the data-length helper.
package synth_midi_pkg;

  typedef enum logic [2:0] {
    EVT_NOTE_OFF = 3'd0,
    EVT_NOTE_ON  = 3'd1,
    EVT_POLY_AT  = 3'd2,
    EVT_CC       = 3'd3,
    EVT_PROG     = 3'd4,
    EVT_CHAN_AT  = 3'd5,
    EVT_PBEND    = 3'd6
  } evt_type_t;

  typedef struct packed {
    evt_type_t  etype;
    logic [3:0] chan;
    logic [6:0] d1;
    logic [6:0] d2;
  } midi_event_t;

  localparam logic [7:0] ST_SYSEX = 8'hF0;
  localparam logic [7:0] ST_EOX   = 8'hF7;
  localparam logic [7:0] RT_MIN   = 8'hF8;

  // Data bytes that follow a status byte; 0 for anything that is not channel voice.
  function automatic logic [1:0] data_len(input logic [7:0] status);
    if (!status[7] || status >= ST_SYSEX) return 2'd0;
    if (status[7:4] == 4'hC || status[7:4] == 4'hD) return 2'd1;
    return 2'd2;
  endfunction

endpackage

// File: rtl/midi_msg_parser_if.sv
// Event stream from the parser to the voice engine (valid/ready, show-ahead head).
interface midi_msg_parser_if;
  import synth_midi_pkg::*;

  logic       event_valid;
  logic       event_ready;
  evt_type_t  event_type;
  logic [3:0] event_chan;
  logic [6:0] event_d1;
  logic [6:0] event_d2;

  modport master (output event_valid, event_type, event_chan, event_d1, event_d2,
                  input  event_ready);
  modport slave  (input  event_valid, event_type, event_chan, event_d1, event_d2,
                  output event_ready);
endinterface

// File: rtl/midi_msg_parser_fifo.sv
// Show-ahead event FIFO; drops on full-without-pop and flags a sticky overflow.
module midi_evt_fifo
  import synth_midi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        reg_clk,
  input  logic        reset_reg_N,
  input  logic        push,
  input  midi_event_t push_evt,
  input  logic        pop_rdy,
  output logic        head_valid,
  output midi_event_t head_evt,
  output logic        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);

  midi_event_t   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop, wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && pop_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_en = push && (!full || pop);

  assign head_valid = !empty;
  assign head_evt   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push && !wr_en) overflow <= 1'b1;
    end
  end

  always_ff @(posedge reg_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_evt;
  end

endmodule

// File: rtl/midi_msg_parser.sv
// Running-status MIDI channel-voice parser feeding a small event FIFO.
module midi_msg_parser
  import synth_midi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               reg_clk,
  input  logic               reset_reg_N,
  input  logic               byte_strobe,
  input  logic [7:0]         midi_byte,
  input  logic               omni_en,
  input  logic [3:0]         chan_sel,
  midi_msg_parser_if.master  ev,
  output logic               overflow,
  output logic [7:0]         run_status
);
  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

  logic        rst_meta, rst_n;
  logic        sync1, sync2, sync3, byte_vld;
  logic [7:0]  byte_q;
  state_t      state, state_nx;
  logic [7:0]  rs_nx;
  logic [6:0]  d1_q, d1_nx;
  logic        push;
  midi_event_t push_evt, head_evt;
  logic        head_valid;

  // Reset asserts immediately, releases on a clock edge.
  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  always_ff @(posedge reg_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      byte_vld <= 1'b0;
      byte_q   <= '0;
    end else begin
      sync1    <= byte_strobe;
      sync2    <= sync1;
      sync3    <= sync2;
      byte_vld <= sync2 && !sync3;
      if (sync2 && !sync3) byte_q <= midi_byte;
    end
  end

  always_ff @(posedge reg_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      run_status <= '0;
      d1_q       <= '0;
    end else begin
      state      <= state_nx;
      run_status <= rs_nx;
      d1_q       <= d1_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rs_nx    = run_status;
    d1_nx    = d1_q;
    push     = 1'b0;
    push_evt = '0;
    if (byte_vld && byte_q < RT_MIN) begin
      if (byte_q[7]) begin
        if (byte_q < ST_SYSEX) begin
          rs_nx    = byte_q;
          state_nx = WAIT_D1;
        end else begin
          rs_nx    = '0;
          state_nx = (byte_q == ST_SYSEX) ? SYSEX : IDLE;
        end
      end else begin
        push_evt.etype = evt_type_t'(run_status[6:4]);
        push_evt.chan  = run_status[3:0];
        case (state)
          WAIT_D1: begin
            d1_nx = byte_q[6:0];
            if (data_len(run_status) == 2'd1) begin
              push_evt.d1 = byte_q[6:0];
              push        = 1'b1;
            end else begin
              state_nx = WAIT_D2;
            end
          end
          WAIT_D2: begin
            push_evt.d1 = d1_q;
            push_evt.d2 = byte_q[6:0];
            push        = 1'b1;
            state_nx    = WAIT_D1;
            if (push_evt.etype == EVT_NOTE_ON && byte_q[6:0] == 7'd0)
              push_evt.etype = EVT_NOTE_OFF;
          end
          default: ;
        endcase
        if (!omni_en && run_status[3:0] != chan_sel) push = 1'b0;
      end
    end
  end

  midi_evt_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .reg_clk     (reg_clk),
    .reset_reg_N (rst_n),
    .push        (push),
    .push_evt    (push_evt),
    .pop_rdy     (ev.event_ready),
    .head_valid  (head_valid),
    .head_evt    (head_evt),
    .overflow    (overflow)
  );

  assign ev.event_valid = head_valid;
  assign ev.event_type  = head_evt.etype;
  assign ev.event_chan  = head_evt.chan;
  assign ev.event_d1    = head_evt.d1;
  assign ev.event_d2    = head_evt.d2;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed scoreboard bench for midi_msg_parser.
module tb_midi_msg_parser;
  import synth_midi_pkg::*;

  logic       reg_clk = 1'b0;
  logic       reset_reg_N = 1'b0;
  logic       byte_strobe = 1'b0;
  logic [7:0] midi_byte = '0;
  logic       omni_en = 1'b1;
  logic [3:0] chan_sel = '0;
  logic       overflow;
  logic [7:0] run_status;
  int         checks = 0;
  int         failures = 0;
  midi_event_t sb [$];

  midi_msg_parser_if ev();

  midi_msg_parser #(.FIFO_DEPTH(4)) dut (
    .reg_clk     (reg_clk),
    .reset_reg_N (reset_reg_N),
    .byte_strobe (byte_strobe),
    .midi_byte   (midi_byte),
    .omni_en     (omni_en),
    .chan_sel    (chan_sel),
    .ev          (ev.master),
    .overflow    (overflow),
    .run_status  (run_status)
  );

  always #5 reg_clk = ~reg_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic midi_event_t mk(input evt_type_t t, input logic [3:0] c,
                                     input logic [6:0] a, input logic [6:0] b);
    midi_event_t e;
    e.etype = t; e.chan = c; e.d1 = a; e.d2 = b;
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge reg_clk);
    midi_byte   = b;
    byte_strobe = 1'b1;
    repeat (6) @(negedge reg_clk);
    byte_strobe = 1'b0;
    repeat (4) @(negedge reg_clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      midi_event_t exp_e;
      while (!ev.event_valid && t < 100) begin
        @(negedge reg_clk);
        t++;
      end
      checks++;
      assert (ev.event_valid === 1'b1) else begin
        failures++;
        $error("FAIL drain_timeout observed=%0b expected=1", ev.event_valid);
      end
      exp_e = (sb.size() > 0) ? sb.pop_front() : '0;
      check($sformatf("event%0d", i),
            32'({ev.event_type, ev.event_chan, ev.event_d1, ev.event_d2}), 32'(exp_e));
      ev.event_ready = 1'b1;
      @(negedge reg_clk);
      ev.event_ready = 1'b0;
    end
    check("empty_after_drain", 32'(ev.event_valid), 32'd0);
  endtask

  initial begin
    ev.event_ready = 1'b0;
    repeat (3) @(negedge reg_clk);
    #1;
    check("rst_valid", 32'(ev.event_valid), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_run_status", 32'(run_status), 0);
    reset_reg_N = 1'b1;
    repeat (4) @(negedge reg_clk);

    // 1: single note-on with latency check on the final byte
    send_byte(8'h90);
    send_byte(8'h3C);
    sb.push_back(mk(EVT_NOTE_ON, 4'd0, 7'h3C, 7'h64));
    @(negedge reg_clk);
    midi_byte   = 8'h64;
    byte_strobe = 1'b1;
    repeat (3) @(negedge reg_clk);
    check("latency_3edges", 32'(ev.event_valid), 0);
    @(negedge reg_clk);
    check("latency_4edges", 32'(ev.event_valid), 1);
    repeat (3) @(negedge reg_clk);
    byte_strobe = 1'b0;
    repeat (4) @(negedge reg_clk);
    check("run_status_90", 32'(run_status), 32'h90);
    drain(sb.size());

    // 2: running status, velocity-zero note-on becomes note-off
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
    send_byte(8'h40); send_byte(8'h7F);
    send_byte(8'h3C); send_byte(8'h00);
    sb.push_back(mk(EVT_NOTE_ON,  4'd0, 7'h3C, 7'h64));
    sb.push_back(mk(EVT_NOTE_ON,  4'd0, 7'h40, 7'h7F));
    sb.push_back(mk(EVT_NOTE_OFF, 4'd0, 7'h3C, 7'h00));
    drain(sb.size());

    // 3: realtime clock inside a message
    send_byte(8'h93); send_byte(8'h3C); send_byte(8'hF8); send_byte(8'h64);
    sb.push_back(mk(EVT_NOTE_ON, 4'd3, 7'h3C, 7'h64));
    check("run_status_93", 32'(run_status), 32'h93);
    drain(sb.size());

    // 4: one-byte messages with running status, then channel filter
    send_byte(8'hC5); send_byte(8'h07); send_byte(8'h0A);
    sb.push_back(mk(EVT_PROG, 4'd5, 7'h07, 7'h00));
    sb.push_back(mk(EVT_PROG, 4'd5, 7'h0A, 7'h00));
    drain(sb.size());
    omni_en  = 1'b0;
    chan_sel = 4'd2;
    send_byte(8'hC5); send_byte(8'h07); send_byte(8'h0A);
    drain(0);
    chan_sel = 4'd5;
    send_byte(8'h01);
    sb.push_back(mk(EVT_PROG, 4'd5, 7'h01, 7'h00));
    drain(sb.size());
    omni_en = 1'b1;

    // 5: sysex and trailing data discarded, then pitch bend
    send_byte(ST_SYSEX); send_byte(8'h7E); send_byte(8'h00); send_byte(ST_EOX);
    send_byte(8'h3C); send_byte(8'h40);
    check("run_status_sysex", 32'(run_status), 0);
    drain(0);
    send_byte(8'hE1); send_byte(8'h00); send_byte(8'h40);
    sb.push_back(mk(EVT_PBEND, 4'd1, 7'h00, 7'h40));
    drain(sb.size());

    // 6: overflow with consumer stalled
    send_byte(8'h91);
    for (int i = 0; i < 5; i++) begin
      send_byte(8'(8'h3C + i));
      send_byte(8'h40);
      if (i < 4) sb.push_back(mk(EVT_NOTE_ON, 4'd1, 7'(7'h3C + i), 7'h40));
    end
    check("overflow_set", 32'(overflow), 1);
    drain(sb.size());
    check("overflow_sticky", 32'(overflow), 1);

    // reset in the middle of a message
    send_byte(8'h92); send_byte(8'h3C);
    @(negedge reg_clk);
    reset_reg_N = 1'b0;
    #1;
    check("midrst_outputs",
          32'({ev.event_valid, ev.event_type, ev.event_chan, ev.event_d1, ev.event_d2}), 0);
    check("midrst_overflow", 32'(overflow), 0);
    check("midrst_run_status", 32'(run_status), 0);
    repeat (2) @(negedge reg_clk);
    reset_reg_N = 1'b1;
    repeat (4) @(negedge reg_clk);
    send_byte(8'h40);
    drain(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
